ucdp_afifo_pktwr: RTL
=====================

Name: ucdp_afifo_pktwr

Overview:
Source-domain packet writer that drives the write port of ucdp_afifo. It accepts one packet of up to beats_p words through a valid/ready handshake. It waits until the FIFO reports enough free space for the whole packet, then writes the packet as back-to-back beats, lowest beat first. The target side therefore never sees a partial packet stalled by missing space.

Parameters:
dwidth_p, 8, width of one FIFO word / beat
awidth_p, 4, FIFO pointer width; FIFO depth = 2^(awidth_p-1); width of the space-available input
beats_p, 4, maximum beats per packet; must be 1..depth (elaboration-time check, fatal otherwise)
lwidth_p (localparam), $clog2(beats_p+1), width of the packet length field

Ports:
src_clk_i  input  1  source clock
src_rst_an_i  input  1  async reset, low-active
pkt_valid_i  input  1  packet offered
pkt_ready_o  output  1  packet accepted when valid&ready
pkt_data_i  input  beats_p*dwidth_p  packet payload; beat k = bits [k*dwidth_p +: dwidth_p]
pkt_len_i  input  lwidth_p  number of beats in the packet
fifo_wr_en_o  output  1  to ucdp_afifo src_wr_en_i
fifo_wr_data_o  output  dwidth_p  to ucdp_afifo src_wr_data_i
fifo_wr_full_i  input  1  from ucdp_afifo src_wr_full_o
fifo_wr_space_avail_i  input  awidth_p  from ucdp_afifo src_wr_space_avail_o
busy_o  output  1  packet held (state other than IDLE)

Behaviour:
Interface decision: reset src_rst_an_i, asynchronous, active-low; clock src_clk_i. All flops are in this single domain.

Reset values:
- State = IDLE.
- pkt_ready_o=1, fifo_wr_en_o=0, fifo_wr_data_o=0, busy_o=0.
- Shift register and beat counter = 0.

FSM states: IDLE, WAIT_SPACE, BURST.

IDLE:
- pkt_ready_o=1.
- On pkt_valid_i, capture pkt_data_i into the shift register and the effective length into the beat counter.
- Effective length = pkt_len_i; values > beats_p clamp to beats_p.
- Effective length 0: the packet is consumed, no write occurs, and the FSM stays in IDLE.
- Effective length >0: go to WAIT_SPACE.

WAIT_SPACE:
- Compare fifo_wr_space_avail_i >= beat counter as an unsigned compare, zero-extended to max(awidth_p, lwidth_p).
- If true, go to BURST next cycle; otherwise hold.
- The compare is always safe: space_avail already accounts for every write up to the previous cycle and is pessimistic about reads.

BURST:
- fifo_wr_en_o = ~fifo_wr_full_i (combinational).
- fifo_wr_data_o = shift register beat 0 (registered source).
- On each cycle with fifo_wr_en_o=1: shift right by dwidth_p, zero fill, decrement the counter.
- When the counter goes 1->0 on a write, go to IDLE.
- If fifo_wr_full_i=1, the beat is held with data unchanged; this only occurs if the FIFO is misused.

Timing:
- Accept at cycle 0; earliest first write at cycle 2.
- A packet of N beats completes at cycle N+1; pkt_ready_o is high again at cycle N+2.
- Minimum packet period is N+2 cycles.
- No overlap: pkt_ready_o=0 in WAIT_SPACE and BURST.

Outside BURST: fifo_wr_en_o=0, and fifo_wr_data_o is driven from the shift register (don't-care to the FIFO).

busy_o = (state != IDLE).

Reset mid-operation: fifo_wr_en_o drops asynchronously, the held packet is discarded, and the FSM returns to IDLE. The system requirement is that the afifo src reset is asserted together with this reset.

pkt_data_i and pkt_len_i are sampled only in the handshake cycle.

Decomposition:
- Package ucdp_afifo_pktwr_pkg holds the state typedef (IDLE, WAIT_SPACE, BURST as a 2-bit enum).
- Shared edge_spec constants stay in the common package.
- No sub-module: FSM, shift register and counter live inline.
- Integration wrapper in the bench only: this block plus ucdp_afifo.

Test Plan:
Bench configuration: dwidth_p=8, awidth_p=4 (depth 8), beats_p=4, paired with ucdp_afifo and a slow tgt clock.
1. Reset release -> pkt_ready_o=1, fifo_wr_en_o=0, busy_o=0, fifo_wr_data_o=0.
2. Empty FIFO (space=8), offer len=4, data=0x44332211 at cycle 0 -> fifo_wr_en_o high cycles 2..5 with data 0x11,0x22,0x33,0x44; pkt_ready_o=1 at cycle 6; target reads the same 4 words in order.
3. FIFO preloaded to space=2, offer len=3 -> WAIT_SPACE held, no fifo_wr_en_o; after one target read (space=3) -> 3 consecutive writes, nothing written early.
4. Offer len=0, then len=7 -> len=0 is consumed with zero writes and ready stays 1; len=7 is clamped to 4 beats written.
5. Force fifo_wr_full_i=1 on the 2nd beat for 3 cycles -> fifo_wr_en_o=0 during those cycles with data held at 0x22; writes resume with 0x22, 0x33, 0x44.
6. Assert src_rst_an_i during the 3rd beat -> fifo_wr_en_o=0 immediately, busy_o=0; after release pkt_ready_o=1 and a new packet is written completely.

Source files
------------

// File: rtl/ucdp_afifo_pktwr_pkg.sv
// Shared types for the ucdp_afifo packet writer.
package ucdp_afifo_pktwr_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_SPACE = 2'd1,
        BURST      = 2'd2
    } pktwr_state_t;

endpackage

// File: rtl/ucdp_afifo_pktwr.sv
// Source-domain packet writer: holds one packet until the afifo has room for all of it,
// then writes it as back-to-back beats, lowest beat first.
module ucdp_afifo_pktwr
    import ucdp_afifo_pktwr_pkg::*;
#(
    parameter int unsigned dwidth_p = 8,
    parameter int unsigned awidth_p = 4,
    parameter int unsigned beats_p  = 4,
    localparam int unsigned lwidth_p = $clog2(beats_p + 1)
) (
    input  logic                          src_clk_i,
    input  logic                          src_rst_an_i,
    input  logic                          pkt_valid_i,
    output logic                          pkt_ready_o,
    input  logic [beats_p*dwidth_p-1:0]   pkt_data_i,
    input  logic [lwidth_p-1:0]           pkt_len_i,
    output logic                          fifo_wr_en_o,
    output logic [dwidth_p-1:0]           fifo_wr_data_o,
    input  logic                          fifo_wr_full_i,
    input  logic [awidth_p-1:0]           fifo_wr_space_avail_i,
    output logic                          busy_o
);

    localparam int unsigned cwidth_p = (awidth_p > lwidth_p) ? awidth_p : lwidth_p;

    if (beats_p < 1 || beats_p > (1 << (awidth_p - 1))) begin : g_beats_check
        $fatal(1, "ucdp_afifo_pktwr: beats_p must be within 1..FIFO depth");
    end

    pktwr_state_t                state_q, state_d;
    logic [beats_p*dwidth_p-1:0] shift_q, shift_d;
    logic [lwidth_p-1:0]         cnt_q, cnt_d;
    logic [lwidth_p-1:0]         eff_len;
    logic                        space_ok;

    assign eff_len  = (pkt_len_i > lwidth_p'(beats_p)) ? lwidth_p'(beats_p) : pkt_len_i;
    assign space_ok = cwidth_p'(fifo_wr_space_avail_i) >= cwidth_p'(cnt_q);

    always_ff @(posedge src_clk_i or negedge src_rst_an_i) begin
        if (!src_rst_an_i) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        pkt_ready_o  = 1'b0;
        fifo_wr_en_o = 1'b0;
        case (state_q)
            IDLE: begin
                pkt_ready_o = 1'b1;
                if (pkt_valid_i) begin
                    shift_d = pkt_data_i;
                    cnt_d   = eff_len;
                    // zero-length packets are consumed without leaving IDLE
                    if (eff_len != '0) begin
                        state_d = WAIT_SPACE;
                    end
                end
            end
            WAIT_SPACE: begin
                if (space_ok) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                fifo_wr_en_o = ~fifo_wr_full_i;
                if (!fifo_wr_full_i) begin
                    shift_d = shift_q >> dwidth_p;
                    cnt_d   = cnt_q - lwidth_p'(1);
                    if (cnt_q == lwidth_p'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fifo_wr_data_o = shift_q[dwidth_p-1:0];
    assign busy_o         = (state_q != IDLE);

endmodule
